// File: rtl/instr_prefetch_pkg.sv
// Shared core constants and helpers for the instruction fetch front end.
//   XLEN        : architectural address/data width
//   INSTR_BYTES : size of one instruction word in bytes
//   align_word  : clears the byte-offset bits of an address
package instr_prefetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(INSTR_BYTES - XLEN'(1));
  endfunction

endpackage

// File: rtl/instr_prefetch_if_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous flush of all entries (same effect as rst)
//   push       : write push_data (ignored when full unless popping in the same cycle)
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : head entry, valid while !empty
//   empty      : no entries held
//   count      : number of entries held (0..DEPTH)
module if_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (cnt == '0);
  assign count    = cnt;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues word-aligned fetches while buffer credit
// remains, buffers in-order responses tagged with their PC, and discards
// responses that were in flight across a redirect (flush).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   flush, flush_addr            : redirect to flush_addr (low 2 bits ignored)
//   imem_req, imem_addr          : fetch request and its address
//   imem_gnt                     : request accepted this cycle
//   imem_rvalid, imem_rdata      : in-order read response
//   out_valid, out_ready         : decode handshake
//   out_pc, out_instr            : PC and instruction of the buffer head
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              grant;
  logic              rsp_ok;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [2*XLEN-1:0] head;

  // Every issued request reserves a buffer slot, so kept responses always fit.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req    = !rst && !flush && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_ok = imem_rvalid && (outstanding != '0);
  assign push   = rsp_ok && (discard == '0) && !flush;
  assign pop    = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (flush) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc    <= align_word(flush_addr);
      resp_pc     <= align_word(flush_addr);
      outstanding <= outstanding - CNT_W'(rsp_ok);
      discard     <= outstanding - CNT_W'(rsp_ok);
    end else begin
      if (grant) fetch_pc <= fetch_pc + INSTR_BYTES;
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp_ok);
      if (rsp_ok) begin
        if (discard != '0) discard <= discard - 1'b1;
        else               resp_pc <= resp_pc + INSTR_BYTES;
      end
    end
  end

  if_fifo #(
    .DATA_W (2*XLEN),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty && !rst;
  assign out_pc    = head[2*XLEN-1:XLEN];
  assign out_instr = head[XLEN-1:0];

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: a transaction-level model (queues of
// in-flight fetches and buffered instructions) predicts the outputs every cycle,
// with directed scenarios pinned by literal expectations, then random traffic.
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] flush_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  always #5 clk = ~clk;

  instr_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_addr(flush_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  typedef struct { logic [31:0] addr; bit keep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        inflight[$];
  ent_t        buf_m[$];
  logic [31:0] m_fetch_pc;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit exp_req();
    return !rst && !flush && ((buf_m.size() + inflight.size()) < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs of the cycle just ended.
  task automatic model_step();
    bit req;
    ent_t e;
    req_t r;
    req = exp_req();
    if (rst) begin
      m_fetch_pc = RESET_PC;
      inflight.delete();
      buf_m.delete();
    end else if (flush) begin
      if (imem_rvalid && inflight.size() > 0) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].keep = 1'b0;
      buf_m.delete();
      m_fetch_pc = flush_addr & 32'hFFFF_FFFC;
    end else begin
      if (buf_m.size() > 0 && out_ready) void'(buf_m.pop_front());
      if (imem_rvalid && inflight.size() > 0) begin
        r = inflight.pop_front();
        if (r.keep) begin
          e.pc = r.addr;
          e.instr = imem_rdata;
          buf_m.push_back(e);
        end
      end
      if (req && imem_gnt) begin
        r.addr = m_fetch_pc;
        r.keep = 1'b1;
        inflight.push_back(r);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input int gnt_pct, input int rv_pct, input int rdy_pct, input bit stray);
    imem_gnt  = ($urandom_range(99) < gnt_pct);
    out_ready = ($urandom_range(99) < rdy_pct);
    if (inflight.size() > 0) begin
      imem_rvalid = ($urandom_range(99) < rv_pct);
      imem_rdata  = word_at(inflight[0].addr);
    end else begin
      imem_rvalid = stray && ($urandom_range(9) == 0);
      imem_rdata  = $urandom;
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    flush = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("imem_req", imem_req, exp_req());
    if (exp_req()) chk("imem_addr", imem_addr, m_fetch_pc);
    chk("out_valid", out_valid, (!rst && buf_m.size() > 0));
    if (!rst && buf_m.size() > 0) begin
      chk("out_pc", out_pc, buf_m[0].pc);
      chk("out_instr", out_instr, buf_m[0].instr);
    end
  end

  initial begin
    int grants;
    int nseen;
    rst = 1'b1; flush = 1'b0; flush_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    m_fetch_pc = RESET_PC;

    // Streaming: addresses 0,4,8 and one instruction per cycle after fill.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(); rst = 1'b0; flush = 1'b0; drive(100, 100, 100, 0); #2;
      if (k < 3) chk("stream_addr", imem_addr, 32'(4 * k));
      if (k >= 2 && k < 5) begin
        chk("stream_valid", {31'b0, out_valid}, 32'd1);
        chk("stream_pc", out_pc, 32'(4 * (k - 2)));
        chk("stream_instr", out_instr, word_at(32'(4 * (k - 2))));
      end
    end

    // Back-pressure: exactly DEPTH grants, then requests stop until a pop.
    do_reset();
    grants = 0;
    for (int k = 0; k < 12; k++) begin
      step(); rst = 1'b0; drive(100, 100, 0, 0); #2;
      if (imem_req && imem_gnt) grants++;
    end
    chk("bp_grants", 32'(grants), 32'd4);
    chk("bp_req_off", {31'b0, imem_req}, 32'd0);
    chk("bp_head_pc", out_pc, 32'd0);
    for (int i = 0; i < 4; i++) chk("bp_model_pc", buf_m[i].pc, 32'(4 * i));
    step(); drive(100, 100, 100, 0); #2;
    step(); drive(100, 100, 100, 0); #2;
    chk("bp_resume_req", {31'b0, imem_req}, 32'd1);
    chk("bp_resume_addr", imem_addr, 32'h10);

    // Flush with two responses in flight: both dropped, target aligned.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step(); rst = 1'b0; drive(100, 0, 100, 0);
    end
    step(); flush = 1'b1; flush_addr = 32'h0000_0203; drive(100, 0, 100, 0); #2;
    chk("flush_no_req", {31'b0, imem_req}, 32'd0);
    step(); flush = 1'b0; drive(0, 100, 100, 0); #2;
    chk("flush_addr_aligned", imem_addr, 32'h200);
    nseen = 0;
    for (int k = 0; k < 10; k++) begin
      step(); drive(100, 100, 100, 0); #2;
      if (out_valid && nseen == 0) begin
        chk("flush_first_pc", out_pc, 32'h200);
        nseen = 1;
      end
    end
    chk("flush_seen", 32'(nseen), 32'd1);

    // Address wrap at the top of the address space.
    do_reset();
    step(); rst = 1'b0; flush = 1'b1; flush_addr = 32'hFFFF_FFFC; drive(0, 0, 100, 0);
    step(); flush = 1'b0; drive(100, 100, 100, 0); #2;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(); drive(100, 100, 100, 0); #2;
    chk("wrap_addr1", imem_addr, 32'h0);
    nseen = 0;
    for (int k = 0; k < 6; k++) begin
      step(); drive(100, 100, 100, 0); #2;
      if (out_valid) begin
        if (nseen == 0) chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        if (nseen == 1) chk("wrap_pc1", out_pc, 32'h0);
        nseen++;
      end
    end
    chk("wrap_seen", 32'(nseen >= 2), 32'd1);

    // Reset with three outstanding requests; stray responses afterwards.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(); rst = 1'b0; drive(100, 0, 0, 0);
    end
    step(); rst = 1'b1; drive(0, 100, 100, 0); #2;
    chk("rst_req_off", {31'b0, imem_req}, 32'd0);
    chk("rst_valid_off", {31'b0, out_valid}, 32'd0);
    step(); rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom; out_ready = 1'b1; #2;
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid_after", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom; #2;
      chk("stray_ignored", {31'b0, out_valid}, 32'd0);
    end

    // Random traffic: grants, response gaps, back-pressure, flushes, resets.
    for (int k = 0; k < 3000; k++) begin
      step();
      rst   = ($urandom_range(199) == 0);
      flush = ($urandom_range(24) == 0);
      flush_addr = $urandom;
      drive(60, 60, 70, 1);
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, the prefetch buffer entries and max outstanding requests; power of 2, >=2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  redirect request from execute/branch.
REQ-006 SHALL have port flush_addr  input  32  absolute redirect target; bits[1:0] ignored, treated as 0.
REQ-007 SHALL have port imem_req  output  1  fetch request valid.
REQ-008 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-009 SHALL have port imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-010 SHALL have port imem_rvalid  input  1  in-order read response valid, at least 1 cycle after grant.
REQ-011 SHALL have port imem_rdata  input  32  response instruction word.
REQ-012 SHALL have port out_valid  output  1  buffered instruction available.
REQ-013 SHALL have port out_ready  input  1  decode accepts instruction.
REQ-014 SHALL have ports out_pc and out_instr  output  32 each  PC and word of the head entry.

Function
REQ-015 SHALL drive imem_req=1 iff !flush and (fifo_count + outstanding) < DEPTH; imem_addr = fetch_pc.
REQ-016 SHALL, on imem_req&imem_gnt, advance fetch_pc by 4 (mod 2^32) and increment outstanding.
REQ-017 SHALL, on imem_rvalid, decrement outstanding; if discard>0, decrement discard and drop the word, else push {resp_pc, imem_rdata} and advance resp_pc by 4 (mod 2^32).
REQ-018 SHALL drive out_valid = fifo not empty; out_pc/out_instr from head; pop on out_valid&out_ready.
REQ-019 SHALL give latency rvalid (cycle N) -> out_valid (cycle N+1); no combinational rdata->out path.
REQ-020 SHALL allow simultaneous push and pop, including when full; count unchanged.
REQ-021 SHALL never overflow: credit check of REQ-015 guarantees a slot for every kept response.
REQ-022 SHALL ignore imem_rvalid when outstanding=0 (protocol violation, no state change).
REQ-023 SHALL give flush priority: in the flush cycle, no request, no pop; next cycle fetch_pc=resp_pc=flush_addr&~3, fifo empty, discard = outstanding - imem_rvalid(this cycle) + discard_prev adjustment, i.e. every response still in flight is dropped.
REQ-024 SHALL accept back-to-back flushes; last one wins, discard accumulates all in-flight responses.
REQ-025 SHALL hold all state when imem_gnt=0 and no response, except out pop.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set fetch_pc=resp_pc=RESET_PC, fifo empty, outstanding=0, discard=0.
REQ-027 SHALL drive imem_req=0 and out_valid=0 during the reset cycle; reset mid-operation discards everything, late responses after reset are ignored per REQ-022.

Structure
REQ-028 SHALL place XLEN=32 and INSTR_BYTES=4 constants in the shared core package.
REQ-029 SHALL implement the buffer as sub-module if_fifo (synchronous FIFO, width 64, depth DEPTH, with clear input).
REQ-030 SHALL size outstanding and discard counters as $clog2(DEPTH)+1 bits.

Verification
REQ-031 Reset, gnt=1, rvalid one cycle after each grant, ready=1 -> addresses 0,4,8,...; out_pc 0,4,8 with matching data, one per cycle after fill.
REQ-032 out_ready=0, DEPTH=4 -> exactly 4 grants then imem_req=0; fifo holds PCs 0..12; ready=1 resumes requests.
REQ-033 2 outstanding, flush with flush_addr=32'h100 -> both late responses dropped; first out_pc=32'h100.
REQ-034 flush with flush_addr=32'h203 -> imem_addr=32'h200.
REQ-035 fetch_pc=32'hFFFF_FFFC granted -> next imem_addr=32'h0, out_pc wraps likewise.
REQ-036 rst asserted with 3 outstanding -> next cycle imem_addr=RESET_PC, out_valid=0, stray rvalids ignored.
